// File: rtl/apb_slave_mem.sv
// APB completer: read-only ID word plus read/write word memory,
// fixed wait states and PSLVERR on bad accesses.
//
// Ports:
//   HCLK     clock, rising edge
//   HRESETn  synchronous active-low reset
//   PSEL     slave select
//   PENABLE  APB access phase
//   PWRITE   1 = write, 0 = read
//   PADDR    byte address
//   PWDATA   write data
//   PRDATA   read data, registered, nonzero only in the PREADY cycle
//   PREADY   transfer complete, registered, one-cycle pulse
//   PSLVERR  error response, registered, valid with PREADY
module apb_slave_mem #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA5B0_0001
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned OFS_W = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] WIN = OFS_W'(DEPTH) << 2;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t state_q;
   state_t state_n;

   logic [3:0]            cnt_q;
   logic [3:0]            cnt_n;
   logic [IDX_W-1:0]      idx_q;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  err_q;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH:0]   offset;
   logic [IDX_W-1:0]      idx_in;
   logic                  err_in;
   logic [DATA_WIDTH-1:0] word_rd;

   logic                  setup;
   logic                  mem_we;
   logic                  ready_n;
   logic                  slverr_n;
   logic [DATA_WIDTH-1:0] rdata_n;

   // One extra bit keeps the borrow: an address below the base
   // wraps to a huge offset and fails the window test as well.
   assign offset = {1'b0, PADDR} - {1'b0, BASE_ADDR};
   assign idx_in = offset[IDX_W+1:2];
   assign err_in = (offset >= WIN)
                 | (|PADDR[1:0])
                 | (PWRITE && (idx_in == '0));

   // mem[0] is never written; word 0 always reads the ID.
   assign word_rd = (idx_q == '0) ? ID_VALUE : mem[idx_q];

   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      setup    = 1'b0;
      mem_we   = 1'b0;
      ready_n  = 1'b0;
      slverr_n = 1'b0;
      rdata_n  = '0;
      unique case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               setup   = 1'b1;
               cnt_n   = 4'(WAIT_CYCLES);
               state_n = ACCESS;
            end
         end
         ACCESS: begin
            if (!PSEL) begin
               state_n = IDLE;
            end else if (cnt_q != '0) begin
               cnt_n = cnt_q - 4'd1;
            end else begin
               state_n  = RESP;
               ready_n  = 1'b1;
               slverr_n = err_q;
               mem_we   = write_q && !err_q;
               if (!write_q && !err_q) begin
                  rdata_n = word_rd;
               end
            end
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         PREADY  <= ready_n;
         PSLVERR <= slverr_n;
         PRDATA  <= rdata_n;
         if (setup) begin
            idx_q   <= idx_in;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            err_q   <= err_in;
         end
         if (mem_we) begin
            mem[idx_q] <= wdata_q;
         end
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: two instances at base 0x100,
// one with two wait states and one with none.
module tb_apb_slave_mem;

   logic        hclk;
   logic        hresetn;
   logic        psel2;
   logic        psel0;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata2;
   logic        pready2;
   logic        pslverr2;
   logic [31:0] prdata0;
   logic        pready0;
   logic        pslverr0;

   int n_pass;
   int n_total;

   localparam logic [31:0] ID = 32'hA5B0_0001;

   apb_slave_mem #(
      .BASE_ADDR(32'h100),
      .WAIT_CYCLES(2)
   ) u_slow (
      .HCLK(hclk),
      .HRESETn(hresetn),
      .PSEL(psel2),
      .PENABLE(penable),
      .PWRITE(pwrite),
      .PADDR(paddr),
      .PWDATA(pwdata),
      .PRDATA(prdata2),
      .PREADY(pready2),
      .PSLVERR(pslverr2)
   );

   apb_slave_mem #(
      .BASE_ADDR(32'h100),
      .WAIT_CYCLES(0)
   ) u_fast (
      .HCLK(hclk),
      .HRESETn(hresetn),
      .PSEL(psel0),
      .PENABLE(penable),
      .PWRITE(pwrite),
      .PADDR(paddr),
      .PWDATA(pwdata),
      .PRDATA(prdata0),
      .PREADY(pready0),
      .PSLVERR(pslverr0)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   function automatic logic rdy(input bit f);
      return f ? pready0 : pready2;
   endfunction

   function automatic logic [31:0] rd(input bit f);
      return f ? prdata0 : prdata2;
   endfunction

   function automatic logic er(input bit f);
      return f ? pslverr0 : pslverr2;
   endfunction

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic idle(input int n);
      psel2   = 1'b0;
      psel0   = 1'b0;
      penable = 1'b0;
      repeat (n) step();
   endtask

   // Full transfer starting with the setup cycle now. Returns the
   // access-cycle count up to and including the PREADY cycle, and
   // whether PRDATA/PSLVERR were nonzero while PREADY was low.
   task automatic xfer(
      input  bit          f,
      input  bit          wr,
      input  logic [31:0] addr,
      input  logic [31:0] acc_addr,
      input  logic [31:0] wdata,
      output logic [31:0] rdata,
      output logic        err,
      output int          cycles,
      output bit          dirty
   );
      if (f) psel0 = 1'b1;
      else psel2 = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      step();
      penable = 1'b1;
      paddr   = acc_addr;
      pwdata  = ~wdata;
      cycles  = 1;
      dirty   = 1'b0;
      while (!rdy(f) && cycles < 40) begin
         if (rd(f) !== '0 || er(f) !== 1'b0) dirty = 1'b1;
         step();
         cycles++;
      end
      rdata = rd(f);
      err   = er(f);
      step();
   endtask

   task automatic test_reset();
      n_total++;
      if ({pready2, pslverr2, prdata2} !== 34'b0)
         $display("FAIL reset_slow: got %b %b %h want 0",
                  pready2, pslverr2, prdata2);
      else n_pass++;
      n_total++;
      if ({pready0, pslverr0, prdata0} !== 34'b0)
         $display("FAIL reset_fast: got %b %b %h want 0",
                  pready0, pslverr0, prdata0);
      else n_pass++;
   endtask

   task automatic test_read_id();
      logic [31:0] d;
      logic e;
      int c;
      bit z;
      xfer(0, 0, 32'h100, 32'h100, '0, d, e, c, z);
      n_total++;
      if (c !== 4) $display("FAIL id_cycles: got %0d want 4", c);
      else n_pass++;
      n_total++;
      if (d !== ID) $display("FAIL id_data: got %h want %h", d, ID);
      else n_pass++;
      n_total++;
      if (e !== 1'b0) $display("FAIL id_err: got %b want 0", e);
      else n_pass++;
      n_total++;
      if (z !== 1'b0) $display("FAIL id_quiet: got %b want 0", z);
      else n_pass++;
      n_total++;
      if ({pready2, pslverr2, prdata2} !== 34'b0)
         $display("FAIL id_clear: got %b %b %h want 0",
                  pready2, pslverr2, prdata2);
      else n_pass++;
      idle(1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic e;
      int c;
      bit z;
      time t0;
      t0 = $time;
      xfer(0, 1, 32'h104, 32'h104, 32'hDEADBEEF, d, e, c, z);
      n_total++;
      if (e !== 1'b0 || c !== 4 || d !== '0)
         $display("FAIL b2b_write: got err %b cyc %0d data %h want 0 4 0",
                  e, c, d);
      else n_pass++;
      xfer(0, 0, 32'h104, 32'h104, '0, d, e, c, z);
      n_total++;
      if (d !== 32'hDEADBEEF)
         $display("FAIL b2b_read: got %h want deadbeef", d);
      else n_pass++;
      n_total++;
      if (e !== 1'b0 || c !== 4)
         $display("FAIL b2b_rd_resp: got err %b cyc %0d want 0 4", e, c);
      else n_pass++;
      n_total++;
      if ($time - t0 !== 100)
         $display("FAIL b2b_time: got %0t want 100", $time - t0);
      else n_pass++;
      idle(1);
   endtask

   logic [31:0] err_addr [5] = '{32'h100, 32'h200, 32'h0FC,
                                 32'h106, 32'h204};
   bit          err_wr   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   task automatic test_errors();
      logic [31:0] d;
      logic e;
      int c;
      bit z;
      for (int i = 0; i < 5; i++) begin
         xfer(0, err_wr[i], err_addr[i], err_addr[i],
              32'h5555_5555, d, e, c, z);
         n_total++;
         if (e !== 1'b1 || d !== '0 || c !== 4 || z !== 1'b0)
            $display("FAIL err_%h: got err %b data %h cyc %0d want 1 0 4",
                     err_addr[i], e, d, c);
         else n_pass++;
      end
      xfer(0, 0, 32'h100, 32'h100, '0, d, e, c, z);
      n_total++;
      if (d !== ID || e !== 1'b0)
         $display("FAIL err_id_kept: got %h %b want %h 0", d, e, ID);
      else n_pass++;
      xfer(0, 0, 32'h104, 32'h104, '0, d, e, c, z);
      n_total++;
      if (d !== 32'hDEADBEEF || e !== 1'b0)
         $display("FAIL err_no_alias: got %h %b want deadbeef 0", d, e);
      else n_pass++;
      xfer(0, 0, 32'h1FC, 32'h1FC, '0, d, e, c, z);
      n_total++;
      if (d !== '0 || e !== 1'b0)
         $display("FAIL last_word: got %h %b want 0 0", d, e);
      else n_pass++;
      idle(1);
   endtask

   task automatic test_stray_enable();
      int hits;
      hits    = 0;
      psel2   = 1'b1;
      penable = 1'b1;
      pwrite  = 1'b0;
      paddr   = 32'h100;
      repeat (5) begin
         step();
         if (pready2 !== 1'b0) hits++;
      end
      n_total++;
      if (hits !== 0)
         $display("FAIL stray_enable: got %0d pulses want 0", hits);
      else n_pass++;
      idle(1);
   endtask

   task automatic test_zero_wait();
      logic [31:0] d;
      logic e;
      int c;
      bit z;
      xfer(1, 0, 32'h100, 32'h100, '0, d, e, c, z);
      n_total++;
      if (d !== ID || c !== 2 || e !== 1'b0)
         $display("FAIL fast_id: got %h cyc %0d err %b want %h 2 0",
                  d, c, e, ID);
      else n_pass++;
      for (int a = 32'h104; a <= 32'h1FC; a += 4) begin
         xfer(1, 0, 32'(a), 32'(a), '0, d, e, c, z);
         n_total++;
         if (d !== '0 || c !== 2 || e !== 1'b0 || z !== 1'b0)
            $display("FAIL fast_rd_%h: got %h cyc %0d err %b want 0 2 0",
                     a, d, c, e);
         else n_pass++;
      end
      xfer(1, 1, 32'h1FC, 32'h1FC, 32'h0BADF00D, d, e, c, z);
      xfer(1, 0, 32'h1FC, 32'h1FC, '0, d, e, c, z);
      n_total++;
      if (d !== 32'h0BADF00D || c !== 2)
         $display("FAIL fast_rw: got %h cyc %0d want 0badf00d 2", d, c);
      else n_pass++;
      idle(1);
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] d;
      logic e;
      int c;
      bit z;
      int hits;
      psel2   = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h108;
      pwdata  = 32'h12345678;
      step();
      penable = 1'b1;
      hresetn = 1'b0;
      step();
      n_total++;
      if ({pready2, pslverr2, prdata2} !== 34'b0)
         $display("FAIL rst_mid_out: got %b %b %h want 0",
                  pready2, pslverr2, prdata2);
      else n_pass++;
      psel2   = 1'b0;
      penable = 1'b0;
      hresetn = 1'b1;
      hits    = 0;
      repeat (5) begin
         step();
         if (pready2 !== 1'b0) hits++;
      end
      n_total++;
      if (hits !== 0)
         $display("FAIL rst_mid_pulse: got %0d pulses want 0", hits);
      else n_pass++;
      xfer(0, 0, 32'h108, 32'h108, '0, d, e, c, z);
      n_total++;
      if (d !== '0 || e !== 1'b0)
         $display("FAIL rst_mid_108: got %h %b want 0 0", d, e);
      else n_pass++;
      xfer(0, 0, 32'h104, 32'h104, '0, d, e, c, z);
      n_total++;
      if (d !== '0)
         $display("FAIL rst_ram_clr: got %h want 0", d);
      else n_pass++;
      idle(1);
   endtask

   task automatic test_abort();
      logic [31:0] d;
      logic e;
      int c;
      bit z;
      int hits;
      psel2   = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h10C;
      pwdata  = 32'hCAFE_0001;
      step();
      penable = 1'b1;
      step();
      psel2   = 1'b0;
      penable = 1'b0;
      hits    = 0;
      repeat (6) begin
         step();
         if (pready2 !== 1'b0) hits++;
      end
      n_total++;
      if (hits !== 0)
         $display("FAIL abort_pulse: got %0d pulses want 0", hits);
      else n_pass++;
      xfer(0, 0, 32'h10C, 32'h10C, '0, d, e, c, z);
      n_total++;
      if (d !== '0)
         $display("FAIL abort_10c: got %h want 0", d);
      else n_pass++;
      xfer(0, 1, 32'h10C, 32'h110, 32'h11111111, d, e, c, z);
      n_total++;
      if (e !== 1'b0 || c !== 4)
         $display("FAIL moved_wr: got err %b cyc %0d want 0 4", e, c);
      else n_pass++;
      xfer(0, 0, 32'h10C, 32'h10C, '0, d, e, c, z);
      n_total++;
      if (d !== 32'h11111111)
         $display("FAIL moved_10c: got %h want 11111111", d);
      else n_pass++;
      xfer(0, 0, 32'h110, 32'h110, '0, d, e, c, z);
      n_total++;
      if (d !== '0)
         $display("FAIL moved_110: got %h want 0", d);
      else n_pass++;
      idle(1);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      hresetn = 1'b0;
      psel2   = 1'b0;
      psel0   = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      repeat (2) step();
      test_reset();
      hresetn = 1'b1;
      step();
      test_read_id();
      test_back_to_back();
      test_errors();
      test_stray_enable();
      test_zero_wait();
      test_reset_mid_write();
      test_abort();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer that answers transfers from the AHB-to-APB bridge on one PSELx line. It holds a read-only ID word and a read/write word memory, inserts a fixed number of wait states, and flags bad accesses with PSLVERR. Each bridge slave window is 256 bytes, so one instance fills one window with the default DEPTH.

## Interface
- ADDR_WIDTH, 32: PADDR width.
- DATA_WIDTH, 32: PWDATA/PRDATA width; word = 4 bytes.
- BASE_ADDR, 32'h000: first byte address of the window.
- DEPTH, 64: number of words, including the ID word; power of 2, ≥2.
- WAIT_CYCLES, 2: extra PREADY-low access cycles, 0..15.
- ID_VALUE, 32'hA5B0_0001: read value of word 0.

Ports:
- HCLK  in  1  clock; all logic on the rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- PSEL  in  1  this slave's PSELx bit.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data; registered.
- PREADY  out  1  transfer complete; registered.
- PSLVERR  out  1  error response, valid only while PREADY=1; registered.

## Operation
- Word index: idx = (PADDR − BASE_ADDR) >> 2.
- Error when any of these holds:
  - PADDR < BASE_ADDR.
  - PADDR > BASE_ADDR + 4·DEPTH − 1.
  - PADDR[1:0] ≠ 0.
  - Write with idx == 0.
- Word 0 reads ID_VALUE. Words 1..DEPTH−1 are RAM, reset to 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - PSEL=1 and PENABLE=0: latch PADDR, PWRITE, PWDATA and the error flag; load cnt ← WAIT_CYCLES; go to ACCESS.
  - PSEL=1 and PENABLE=1 without a prior setup: ignore, stay in IDLE.
- ACCESS:
  - PSEL=0: abort to IDLE, no write, outputs stay 0.
  - cnt ≠ 0: cnt ← cnt − 1.
  - cnt == 0: go to RESP and set PREADY ← 1 and PSLVERR ← err.
    - Write with no error: RAM[idx] ← latched PWDATA at this same edge.
    - Read with no error: PRDATA ← word[idx].
    - Error or write: PRDATA ← 0.
- RESP: at the next edge clear PREADY, PSLVERR and PRDATA; go to IDLE.
- The transfer uses only the values latched in setup. PADDR/PWDATA changes during ACCESS are ignored.
- An erroring write never changes RAM or the ID word.

## Timing
- Reset (HRESETn=0 at an edge):
  - state ← IDLE, cnt ← 0, PREADY ← 0, PSLVERR ← 0, PRDATA ← 0, all RAM words ← 0.
  - Takes priority over everything, including mid-ACCESS; a pending write is discarded.
- Setup cycle is S. PREADY is 0 in cycles S+1 .. S+WAIT_CYCLES+1 and 1 in cycle S+WAIT_CYCLES+2.
  - Access phase = WAIT_CYCLES+2 cycles; whole transfer = WAIT_CYCLES+3 cycles.
  - With WAIT_CYCLES=0 there is still one PREADY-low access cycle.
- PREADY is high for exactly one cycle per completed transfer. PRDATA and PSLVERR are valid only in that cycle and are 0 otherwise.
- Back-to-back: a setup in the cycle after RESP is accepted, because the FSM is in IDLE then. There are no idle bubbles beyond the protocol.
- Read-after-write to the same word returns the new data, since the write commits before PREADY rises.
- No internal timeouts; cnt never wraps, because it is loaded only in IDLE.

## Test plan
- Reset, then read word 0 with BASE_ADDR=0x100, WAIT_CYCLES=2, PADDR=0x100 -> PREADY low 3 access cycles then high 1; PRDATA=0xA5B00001, PSLVERR=0.
- Write 0xDEADBEEF to 0x104, then read 0x104 back-to-back -> write completes with PSLVERR=0; read PRDATA=0xDEADBEEF; each transfer takes 5 cycles.
- Error cases, each -> PSLVERR=1 in the PREADY cycle, PRDATA=0, memory unchanged:
  - Write to 0x100 (ID word); a following read of 0x100 still returns 0xA5B00001.
  - Read 0x200 (out of range).
  - Read 0x0FC (below BASE_ADDR).
  - Read 0x106 (misaligned).
- WAIT_CYCLES=0, reads of 0x104..0x1FC -> each shows PREADY high in the 2nd access cycle; unwritten words read 0.
- Start a write of 0x12345678 to 0x108, assert HRESETn=0 in access cycle 1 -> outputs 0 at the next edge; a read of 0x108 after reset returns 0.
- Drop PSEL mid-ACCESS on a write to 0x10C, or drive PADDR to 0x110 during ACCESS -> dropped: no PREADY pulse, 0x10C unchanged; PADDR change: the write lands at 0x10C only.
